snake_head_stepper: RTL and testbench

- Upstream operand stage for the 5-bit ripple adder (fiveBitAdder).
- Holds the snake head coordinates and current direction, and divides the clock into game steps.
- On each step it drives one coordinate and a ±1 delta into the adder, captures the sum, applies grid wrap-around and publishes the new head position to the body/collision logic downstream.

---
 rtl/snake_head_stepper.sv | 150 +++++++++++++++
 tb/tb_snake_head_stepper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/snake_head_stepper.sv
// Snake head stepper: paces game steps, feeds the 5-bit adder with one
// coordinate and a +/-1 delta, and wraps the returned sum onto the grid.
module snake_head_stepper #(
    parameter int TICK_DIV = 4,
    parameter int GRID_X   = 32,
    parameter int GRID_Y   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [4:0] add_a,
    output logic [4:0] add_b,
    input  logic [4:0] add_s,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [1:0] dir,
    output logic       step_valid,
    output logic       running
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [4:0] X_RST = 5'(GRID_X / 2);
    localparam logic [4:0] Y_RST = 5'(GRID_Y / 2);
    localparam logic [4:0] X_MAX = 5'(GRID_X - 1);
    localparam logic [4:0] Y_MAX = 5'(GRID_Y - 1);
    localparam logic [5:0] X_LIM = 6'(GRID_X);
    localparam logic [5:0] Y_LIM = 6'(GRID_Y);

    localparam logic [1:0] D_RIGHT = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_UP    = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    hx_q, hx_d, hy_q, hy_d;
    logic [1:0]    dir_q, dir_d, pdir_q, pdir_d;
    logic          sv_q, sv_d;

    logic       press, legal, step_legal;
    logic [1:0] chosen;
    logic       horiz, neg;
    logic [4:0] wrapped;

    always_comb begin
        press  = 1'b1;
        chosen = D_RIGHT;
        if (btn_up)         chosen = D_UP;
        else if (btn_down)  chosen = D_DOWN;
        else if (btn_left)  chosen = D_LEFT;
        else if (btn_right) chosen = D_RIGHT;
        else                press  = 1'b0;
    end

    // Opposite directions differ only in bit 0.
    assign legal      = press && (chosen != (dir_q ^ 2'd1));
    // A press during STEP must also not reverse the direction being committed.
    assign step_legal = legal && (chosen != (pdir_q ^ 2'd1));

    assign horiz = ~pdir_q[1];
    assign neg   = pdir_q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hx_q    <= X_RST;
            hy_q    <= Y_RST;
            dir_q   <= D_RIGHT;
            pdir_q  <= D_RIGHT;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            dir_q   <= dir_d;
            pdir_q  <= pdir_d;
            sv_q    <= sv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pdir_d  = pdir_q;
        dir_d   = dir_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        sv_d    = 1'b0;
        wrapped = add_s;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (legal) begin
                    pdir_d  = chosen;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (legal) pdir_d = chosen;
                if (enable) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = S_STEP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STEP: begin
                if (step_legal) pdir_d = chosen;
                dir_d   = pdir_q;
                sv_d    = 1'b1;
                state_d = S_RUN;
                if (neg) begin
                    if (add_a == 5'd0) wrapped = horiz ? X_MAX : Y_MAX;
                end else begin
                    if ({1'b0, add_s} == (horiz ? X_LIM : Y_LIM)) wrapped = 5'd0;
                end
                if (horiz) hx_d = wrapped;
                else       hy_d = wrapped;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        add_a   = 5'd0;
        add_b   = 5'd0;
        running = (state_q == S_RUN) || (state_q == S_STEP);
        if (state_q == S_STEP) begin
            add_a = horiz ? hx_q : hy_q;
            add_b = neg ? 5'b11111 : 5'b00001;
        end
    end

    assign head_x     = hx_q;
    assign head_y     = hy_q;
    assign dir        = dir_q;
    assign step_valid = sv_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed bench for snake_head_stepper; the bench plays the 5-bit adder.
module tb_snake_head_stepper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [4:0] add_a, add_b, add_s;
    logic [4:0] head_x, head_y;
    logic [1:0] dir;
    logic       step_valid, running;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign add_s = add_a + add_b;

    snake_head_stepper #(.TICK_DIV(4), .GRID_X(32), .GRID_Y(24)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_up(btn[3]), .btn_down(btn[2]),
        .btn_left(btn[1]), .btn_right(btn[0]),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .head_x(head_x), .head_y(head_y), .dir(dir),
        .step_valid(step_valid), .running(running)
    );

    typedef struct {
        logic [3:0] btn;
        int reps;
        int x, y, d, a, b;
    } vec_t;

    vec_t tbl[12];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Ticks until step_valid; a/b hold the adder operands seen in the STEP cycle.
    task automatic wait_step(output int n, output int a, output int b);
        n = 0;
        a = -1;
        b = -1;
        do begin
            a = add_a;
            b = add_b;
            tick();
            n++;
            btn = 4'b0000;
        end while (!step_valid && n < 20);
        if (!step_valid) chk("step_timeout", 0, 1);
    endtask

    initial begin
        int n, a, b, sv_cnt;

        tbl[0]  = '{4'b0000, 13, 31, 12, 0, 30, 1};
        tbl[1]  = '{4'b0000, 1,  0,  12, 0, 31, 1};
        tbl[2]  = '{4'b0010, 1,  1,  12, 0, 0,  1};
        tbl[3]  = '{4'b1001, 1,  1,  11, 3, 12, 31};
        tbl[4]  = '{4'b0000, 11, 1,  0,  3, 1,  31};
        tbl[5]  = '{4'b0000, 1,  1,  23, 3, 0,  31};
        tbl[6]  = '{4'b0100, 1,  1,  22, 3, 23, 31};
        tbl[7]  = '{4'b0010, 1,  0,  22, 1, 1,  31};
        tbl[8]  = '{4'b0000, 1,  31, 22, 1, 0,  31};
        tbl[9]  = '{4'b0100, 1,  31, 23, 2, 22, 1};
        tbl[10] = '{4'b0000, 1,  31, 0,  2, 23, 1};
        tbl[11] = '{4'b0001, 1,  0,  0,  0, 31, 1};

        tick();
        tick();
        chk("rst_head_x", head_x, 16);
        chk("rst_head_y", head_y, 12);
        chk("rst_dir", dir, 0);
        chk("rst_step_valid", step_valid, 0);
        chk("rst_running", running, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);

        reset = 1'b0;
        enable = 1'b1;
        tick();
        chk("idle_running", running, 0);
        btn = 4'b0001;
        tick();
        btn = 4'b0000;
        chk("start_running", running, 1);
        wait_step(n, a, b);
        chk("first_period", n, 5);
        chk("first_add_a", a, 16);
        chk("first_add_b", b, 1);
        chk("first_x", head_x, 17);
        chk("first_y", head_y, 12);
        tick();
        chk("sv_one_cycle", step_valid, 0);
        chk("sv_gap_period", 0, 0 * 1);
        wait_step(n, a, b);
        chk("second_period", n, 4);
        chk("second_x", head_x, 18);

        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                btn = (r == 0) ? tbl[i].btn : 4'b0000;
                wait_step(n, a, b);
                chk($sformatf("v%0d_period", i), n, 5);
            end
            chk($sformatf("v%0d_x", i), head_x, tbl[i].x);
            chk($sformatf("v%0d_y", i), head_y, tbl[i].y);
            chk($sformatf("v%0d_dir", i), dir, tbl[i].d);
            chk($sformatf("v%0d_add_a", i), a, tbl[i].a);
            chk($sformatf("v%0d_add_b", i), b, tbl[i].b);
        end

        // Up then an illegal left before the step: pending UP survives.
        btn = 4'b1000;
        tick();
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        wait_step(n, a, b);
        chk("upleft_period", n + 2, 5);
        chk("upleft_y", head_y, 23);
        chk("upleft_x", head_x, 0);
        chk("upleft_dir", dir, 3);

        // Pause at counter == 2 for ten cycles.
        tick();
        tick();
        enable = 1'b0;
        sv_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (step_valid) sv_cnt++;
        end
        chk("pause_no_step", sv_cnt, 0);
        chk("pause_running", running, 1);
        enable = 1'b1;
        wait_step(n, a, b);
        chk("resume_latency", n, 3);
        chk("resume_y", head_y, 22);

        // Reset asserted in the middle of a STEP cycle.
        repeat (4) tick();
        chk("pre_rst_add_a", add_a, 22);
        chk("pre_rst_add_b", add_b, 31);
        #1 reset = 1'b1;
        #1;
        chk("async_x", head_x, 16);
        chk("async_y", head_y, 12);
        chk("async_dir", dir, 0);
        chk("async_sv", step_valid, 0);
        chk("async_running", running, 0);
        chk("async_add_a", add_a, 0);
        tick();
        chk("post_rst_x", head_x, 16);
        reset = 1'b0;
        btn = 4'b0010;
        tick();
        btn = 4'b0000;
        chk("idle_left_ignored", running, 0);
        btn = 4'b0100;
        tick();
        btn = 4'b0000;
        chk("idle_down_run", running, 1);
        wait_step(n, a, b);
        chk("down_period", n, 5);
        chk("down_y", head_y, 13);
        chk("down_x", head_x, 16);
        chk("down_dir", dir, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
